// File: rtl/demux_rx.sv
// Receive-side byte demultiplexer: checks preamble/SFD, then steers header, ARP, pad and FCS
// bytes onto one registered byte bus with per-section strobes and a byte index.
module demux_rx #(
  parameter int          ARP_LEN     = 28,
  parameter int          PAYLOAD_LEN = 46,
  parameter logic [15:0] ETHERTYPE   = 16'h0806
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic [7:0] rx_data,
  output logic       eth_header_rx_valid,
  output logic       arp_data_rx_valid,
  output logic       fcs_rx_valid,
  output logic [5:0] rx_index,
  output logic       crc_en,
  output logic       rx_frame_done,
  output logic       rx_frame_abort
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, ETH_HEADER, ARP_DATA, PAD, FCS, WAIT_END, DROP
  } state_t;

  localparam int         PAD_LEN   = PAYLOAD_LEN - ARP_LEN;
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TYPE_HI   = 6'd12;
  localparam logic [5:0] ARP_LAST  = 6'(ARP_LEN - 1);
  localparam logic [5:0] PAD_LAST  = 6'(PAD_LEN - 1);
  localparam logic [5:0] FCS_LAST  = 6'd3;
  // A payload made entirely of ARP bytes has no padding section to visit.
  localparam state_t     AFTER_ARP = (PAD_LEN > 0) ? PAD : FCS;

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [2:0] pre_cnt, pre_cnt_nxt;
  logic [7:0] type_hi, type_hi_nxt;
  logic       type_ok;

  logic [7:0] rx_data_nxt;
  logic [5:0] rx_index_nxt;
  logic       hdr_v_nxt, arp_v_nxt, fcs_v_nxt, crc_nxt, done_nxt, abort_nxt;

  // Valid only while the second EtherType byte is on data_in.
  assign type_ok = ({type_hi, data_in} == ETHERTYPE);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state               <= IDLE;
      cnt                 <= '0;
      pre_cnt             <= '0;
      type_hi             <= '0;
      rx_data             <= '0;
      rx_index            <= '0;
      eth_header_rx_valid <= 1'b0;
      arp_data_rx_valid   <= 1'b0;
      fcs_rx_valid        <= 1'b0;
      crc_en              <= 1'b0;
      rx_frame_done       <= 1'b0;
      rx_frame_abort      <= 1'b0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      pre_cnt             <= pre_cnt_nxt;
      type_hi             <= type_hi_nxt;
      rx_data             <= rx_data_nxt;
      rx_index            <= rx_index_nxt;
      eth_header_rx_valid <= hdr_v_nxt;
      arp_data_rx_valid   <= arp_v_nxt;
      fcs_rx_valid        <= fcs_v_nxt;
      crc_en              <= crc_nxt;
      rx_frame_done       <= done_nxt;
      rx_frame_abort      <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    type_hi_nxt = type_hi;
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_nxt   = (data_in == 8'h55) ? PREAMBLE : DROP;
          pre_cnt_nxt = 3'd1;
        end
      end
      PREAMBLE: begin
        if (!data_valid)             state_nxt = IDLE;
        else if (data_in == 8'h55) begin
          if (pre_cnt == 3'd7)       state_nxt = DROP;
          else                       pre_cnt_nxt = pre_cnt + 3'd1;
        end
        else if (data_in == 8'hD5)   state_nxt = ETH_HEADER;
        else                         state_nxt = DROP;
      end
      ETH_HEADER: begin
        if (!data_valid) state_nxt = IDLE;
        else begin
          if (cnt == TYPE_HI)  type_hi_nxt = data_in;
          if (cnt == HDR_LAST) state_nxt = type_ok ? ARP_DATA : DROP;
        end
      end
      ARP_DATA: begin
        if (!data_valid)          state_nxt = IDLE;
        else if (cnt == ARP_LAST) state_nxt = AFTER_ARP;
      end
      PAD: begin
        if (!data_valid)          state_nxt = IDLE;
        else if (cnt == PAD_LAST) state_nxt = FCS;
      end
      FCS: begin
        if (!data_valid)          state_nxt = IDLE;
        else if (cnt == FCS_LAST) state_nxt = WAIT_END;
      end
      WAIT_END: state_nxt = data_valid ? DROP : IDLE;
      DROP:     if (!data_valid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    else                    cnt_nxt = data_valid ? cnt + 6'd1 : cnt;
  end

  always_comb begin
    rx_data_nxt  = rx_data;
    rx_index_nxt = '0;
    hdr_v_nxt    = 1'b0;
    arp_v_nxt    = 1'b0;
    fcs_v_nxt    = 1'b0;
    crc_nxt      = 1'b0;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    case (state)
      ETH_HEADER, ARP_DATA, PAD, FCS: begin
        if (data_valid) begin
          // Pad bytes still drive rx_data so the FCS checker can fold them into the CRC.
          rx_data_nxt  = data_in;
          rx_index_nxt = cnt;
          hdr_v_nxt    = (state == ETH_HEADER);
          arp_v_nxt    = (state == ARP_DATA);
          fcs_v_nxt    = (state == FCS);
          crc_nxt      = (state != FCS);
          abort_nxt    = (state == ETH_HEADER) && (cnt == HDR_LAST) && !type_ok;
        end else begin
          abort_nxt = 1'b1;
        end
      end
      WAIT_END: begin
        done_nxt  = !data_valid;
        abort_nxt = data_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_demux_rx.sv
// Bench for demux_rx: directed and randomised frames checked against a positional frame model
// that predicts section bytes, CRC-covered bytes and done/abort events with their timing.
module tb_demux_rx;

  localparam int          ARP_LEN     = 28;
  localparam int          PAYLOAD_LEN = 46;
  localparam int          PAD_LEN     = PAYLOAD_LEN - ARP_LEN;
  localparam logic [15:0] ETHERTYPE   = 16'h0806;

  logic       aclk;
  logic       areset;
  logic       data_valid;
  logic [7:0] data_in;
  logic [7:0] rx_data;
  logic       eth_header_rx_valid;
  logic       arp_data_rx_valid;
  logic       fcs_rx_valid;
  logic [5:0] rx_index;
  logic       crc_en;
  logic       rx_frame_done;
  logic       rx_frame_abort;

  demux_rx #(
    .ARP_LEN    (ARP_LEN),
    .PAYLOAD_LEN(PAYLOAD_LEN),
    .ETHERTYPE  (ETHERTYPE)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .data_valid         (data_valid),
    .data_in            (data_in),
    .rx_data            (rx_data),
    .eth_header_rx_valid(eth_header_rx_valid),
    .arp_data_rx_valid  (arp_data_rx_valid),
    .fcs_rx_valid       (fcs_rx_valid),
    .rx_index           (rx_index),
    .crc_en             (crc_en),
    .rx_frame_done      (rx_frame_done),
    .rx_frame_abort     (rx_frame_abort)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int excl_viol = 0;

  logic [7:0]  frame_q[$];
  logic [13:0] got_hdr[$], got_arp[$], got_fcs[$];
  logic [13:0] exp_hdr[$], exp_arp[$], exp_fcs[$];
  logic [7:0]  got_crc[$], exp_crc[$];
  int          got_ev_kind[$], got_ev_diff[$], exp_ev_kind[$], exp_ev_diff[$];

  // Event kinds: 1 = frame done, 2 = frame abort; diff = cycles since the last data strobe.
  always @(negedge aclk) begin
    int nv;
    cyc++;
    nv = int'(eth_header_rx_valid) + int'(arp_data_rx_valid) + int'(fcs_rx_valid);
    if (nv > 1 || (rx_frame_done && rx_frame_abort)) excl_viol++;
    if (eth_header_rx_valid) got_hdr.push_back({rx_index, rx_data});
    if (arp_data_rx_valid)   got_arp.push_back({rx_index, rx_data});
    if (fcs_rx_valid)        got_fcs.push_back({rx_index, rx_data});
    if (crc_en)              got_crc.push_back(rx_data);
    if (nv > 0 || crc_en)    last_cyc = cyc;
    if (rx_frame_done) begin
      got_ev_kind.push_back(1);
      got_ev_diff.push_back(cyc - last_cyc);
    end
    if (rx_frame_abort) begin
      got_ev_kind.push_back(2);
      got_ev_diff.push_back(cyc - last_cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "/rx_data"},  32'(rx_data), 0);
    check({tag, "/hdr_v"},    32'(eth_header_rx_valid), 0);
    check({tag, "/arp_v"},    32'(arp_data_rx_valid), 0);
    check({tag, "/fcs_v"},    32'(fcs_rx_valid), 0);
    check({tag, "/rx_index"}, 32'(rx_index), 0);
    check({tag, "/crc_en"},   32'(crc_en), 0);
    check({tag, "/done"},     32'(rx_frame_done), 0);
    check({tag, "/abort"},    32'(rx_frame_abort), 0);
  endtask

  task automatic push_ev(input int kind, input int diff);
    exp_ev_kind.push_back(kind);
    exp_ev_diff.push_back(diff);
  endtask

  // Frame-level reference: locate the SFD, then slice the byte stream into sections by position.
  // A cut index models reset arriving on that byte: the frame ends silently there.
  task automatic model_frame(input int cut);
    int len, n, p, rem, k;
    len = (cut >= 0) ? cut : frame_q.size();
    n = 0;
    while (n < len && frame_q[n] == 8'h55) n++;
    if (n < 1 || n > 7 || n >= len || frame_q[n] != 8'hD5) return;
    p = n + 1;
    rem = len - p;
    for (int i = 0; i < 14 && i < rem; i++) begin
      exp_hdr.push_back({6'(i), frame_q[p+i]});
      exp_crc.push_back(frame_q[p+i]);
    end
    if (rem < 14) begin
      if (cut < 0) push_ev(2, 1);
      return;
    end
    if ({frame_q[p+12], frame_q[p+13]} != ETHERTYPE) begin
      push_ev(2, 0);
      return;
    end
    k = p + 14;
    for (int i = 0; i < ARP_LEN && k + i < len; i++) begin
      exp_arp.push_back({6'(i), frame_q[k+i]});
      exp_crc.push_back(frame_q[k+i]);
    end
    if (rem < 14 + ARP_LEN) begin
      if (cut < 0) push_ev(2, 1);
      return;
    end
    k = p + 14 + ARP_LEN;
    for (int i = 0; i < PAD_LEN && k + i < len; i++) exp_crc.push_back(frame_q[k+i]);
    if (rem < 14 + PAYLOAD_LEN) begin
      if (cut < 0) push_ev(2, 1);
      return;
    end
    k = p + 14 + PAYLOAD_LEN;
    for (int i = 0; i < 4 && k + i < len; i++) exp_fcs.push_back({6'(i), frame_q[k+i]});
    if (rem < 14 + PAYLOAD_LEN + 4) begin
      if (cut < 0) push_ev(2, 1);
    end else if (rem == 14 + PAYLOAD_LEN + 4) begin
      push_ev(1, 1);
    end else begin
      push_ev(2, 1);
    end
  endtask

  task automatic build_frame(input int npre, input logic [15:0] etype);
    frame_q.delete();
    repeat (npre) frame_q.push_back(8'h55);
    frame_q.push_back(8'hD5);
    repeat (12) frame_q.push_back(8'($urandom_range(0, 255)));
    frame_q.push_back(etype[15:8]);
    frame_q.push_back(etype[7:0]);
    repeat (PAYLOAD_LEN + 4) frame_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Drives frame_q contiguously, then holds data_valid low for gap cycles.
  task automatic send_frame(input int gap, input int cut);
    model_frame(cut);
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge aclk);
      areset     = (i == cut);
      data_valid = 1'b1;
      data_in    = frame_q[i];
      if (i == cut) begin
        @(posedge aclk);
        #1;
        check_outputs_zero("reset_mid_outputs");
      end
    end
    @(negedge aclk);
    areset     = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (gap - 1) @(negedge aclk);
  endtask

  task automatic compare_frame(input string tag);
    repeat (2) @(posedge aclk);
    #1;
    check({tag, "/hdr_count"}, got_hdr.size(), exp_hdr.size());
    for (int i = 0; i < exp_hdr.size() && i < got_hdr.size(); i++)
      check({tag, "/hdr_byte"}, 32'(got_hdr[i]), 32'(exp_hdr[i]));
    check({tag, "/arp_count"}, got_arp.size(), exp_arp.size());
    for (int i = 0; i < exp_arp.size() && i < got_arp.size(); i++)
      check({tag, "/arp_byte"}, 32'(got_arp[i]), 32'(exp_arp[i]));
    check({tag, "/fcs_count"}, got_fcs.size(), exp_fcs.size());
    for (int i = 0; i < exp_fcs.size() && i < got_fcs.size(); i++)
      check({tag, "/fcs_byte"}, 32'(got_fcs[i]), 32'(exp_fcs[i]));
    check({tag, "/crc_count"}, got_crc.size(), exp_crc.size());
    for (int i = 0; i < exp_crc.size() && i < got_crc.size(); i++)
      check({tag, "/crc_byte"}, 32'(got_crc[i]), 32'(exp_crc[i]));
    check({tag, "/event_count"}, got_ev_kind.size(), exp_ev_kind.size());
    for (int i = 0; i < exp_ev_kind.size() && i < got_ev_kind.size(); i++) begin
      check({tag, "/event_kind"}, got_ev_kind[i], exp_ev_kind[i]);
      check({tag, "/event_delay"}, got_ev_diff[i], exp_ev_diff[i]);
    end
    check({tag, "/exclusion"}, excl_viol, 0);
    got_hdr.delete(); got_arp.delete(); got_fcs.delete(); got_crc.delete();
    exp_hdr.delete(); exp_arp.delete(); exp_fcs.delete(); exp_crc.delete();
    got_ev_kind.delete(); got_ev_diff.delete(); exp_ev_kind.delete(); exp_ev_diff.delete();
    excl_viol = 0;
  endtask

  initial begin
    int len;
    areset     = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #1;
    check_outputs_zero("reset");
    @(negedge aclk);
    areset = 1'b0;

    build_frame(7, ETHERTYPE);
    send_frame(4, -1);
    compare_frame("good");

    for (int t = 0; t < 4; t++) begin
      build_frame(int'($urandom_range(1, 7)), ETHERTYPE);
      send_frame(4, -1);
      compare_frame("rand_good");
    end

    build_frame(1, ETHERTYPE);
    send_frame(4, -1);
    compare_frame("short_preamble");

    build_frame(8, ETHERTYPE);
    send_frame(4, -1);
    compare_frame("long_preamble");

    build_frame(7, 16'h0800);
    send_frame(4, -1);
    compare_frame("bad_ethertype");

    build_frame(7, ETHERTYPE);
    frame_q = frame_q[0:8+14+10];
    send_frame(4, -1);
    compare_frame("truncated");

    build_frame(7, ETHERTYPE);
    send_frame(4, -1);
    compare_frame("after_truncation");

    build_frame(7, ETHERTYPE);
    frame_q.push_back(8'($urandom_range(0, 255)));
    frame_q.push_back(8'($urandom_range(0, 255)));
    send_frame(4, -1);
    compare_frame("oversize");

    build_frame(7, ETHERTYPE);
    for (int i = 8 + 14 + 6; i < frame_q.size(); i++)
      if (frame_q[i] == 8'h55) frame_q[i] = 8'h5A;
    send_frame(4, 8 + 14 + 5);
    compare_frame("reset_mid");

    build_frame(7, ETHERTYPE);
    send_frame(4, -1);
    compare_frame("after_reset");

    build_frame(3, ETHERTYPE);
    send_frame(1, -1);
    build_frame(5, ETHERTYPE);
    send_frame(4, -1);
    compare_frame("back_to_back");

    for (int t = 0; t < 8; t++) begin
      int npre;
      npre = int'($urandom_range(1, 7));
      build_frame(npre, ($urandom_range(0, 3) == 0) ? 16'h0800 : ETHERTYPE);
      len = int'($urandom_range(npre + 2, frame_q.size() + 2));
      if (len < frame_q.size()) frame_q = frame_q[0:len-1];
      while (frame_q.size() < len) frame_q.push_back(8'($urandom_range(0, 255)));
      send_frame(int'($urandom_range(1, 3)), -1);
      compare_frame("rand_mix");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
